// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Matrix keypad controller. It drives one row low at a time, samples the synchronised
//   columns at the end of each row dwell, debounces a single-key press, emits a binary key
//   code with a one-cycle valid strobe, optionally auto-repeats while the key is held, and
//   debounces the release before scanning resumes.
//
// Ports
//   i_int_osc    : clock, single domain
//   i_reset      : asynchronous reset, active low
//   i_cols_n     : raw column pins, active low, asynchronous to i_int_osc
//   o_rows_n     : row drive, active low, exactly one bit low at all times
//   o_key_code   : accepted key, row*COLS + col, held until the next emit
//   o_key_valid  : one-cycle pulse on first press or auto-repeat
//   o_key_repeat : high together with o_key_valid when the event is an auto-repeat
//   o_key_held   : high from first emit until the release has been debounced
//
// REPEAT_DELAY and REPEAT_RATE must be >= 2 when REPEAT_EN is set.
module keypad_scan_ctrl #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 24000000,
  parameter int unsigned REPEAT_RATE     = 4800000,
  parameter int unsigned KW              = $clog2(ROWS * COLS)
) (
  input  logic            i_int_osc,
  input  logic            i_reset,
  input  logic [COLS-1:0] i_cols_n,
  output logic [ROWS-1:0] o_rows_n,
  output logic [KW-1:0]   o_key_code,
  output logic            o_key_valid,
  output logic            o_key_repeat,
  output logic            o_key_held
);

  localparam int unsigned RowW   = $clog2(ROWS);
  localparam int unsigned ColW   = $clog2(COLS);
  localparam int unsigned DwW    = $clog2(SCAN_DIV);
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [RowW-1:0] RowLast     = RowW'(ROWS - 1);
  localparam logic [DwW-1:0]  DwLast      = DwW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0]  DbLast      = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] RepFirst    = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepReload   = RepW'(REPEAT_RATE);
  localparam logic [KW-1:0]   ColsK       = KW'(COLS);
  localparam logic [ROWS-1:0] RowsNReset  = {{(ROWS - 1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    StScan,
    StDebounce,
    StEmit,
    StHold,
    StRelease
  } state_e;

  state_e            r_state;
  logic [COLS-1:0]   r_sync1;
  logic [COLS-1:0]   r_sync2;
  logic [RowW-1:0]   r_row;
  logic [ROWS-1:0]   r_rows_n;
  logic [ColW-1:0]   r_col;
  logic [DwW-1:0]    r_dwell;
  logic [DbW-1:0]    r_cnt;
  logic [RepW-1:0]   r_rep;
  logic [KW-1:0]     r_key_code;
  logic              r_key_valid;
  logic              r_key_repeat;
  logic              r_key_held;

  logic [COLS-1:0]   w_low;
  logic              w_one_hot;
  logic [ColW-1:0]   w_low_idx;
  logic [COLS-1:0]   w_exp_cols;
  logic              w_col_high;
  logic [RowW-1:0]   w_row_next;
  logic [ROWS-1:0]   w_rows_n_next;
  logic [KW-1:0]     w_code;

  // Two-flop synchroniser; reset to "all released".
  always_ff @(posedge i_int_osc or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_cols_n;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_low     = ~r_sync2;
    w_one_hot = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);
    w_low_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_low[c]) begin
        w_low_idx = ColW'(c);
      end
    end
    // Only the latched column low, every other column released.
    w_exp_cols    = ~(COLS'(1) << r_col);
    w_col_high    = r_sync2[r_col];
    w_row_next    = (r_row == RowLast) ? '0 : r_row + 1'b1;
    w_rows_n_next = ~(ROWS'(1) << w_row_next);
    w_code        = KW'(r_row) * ColsK + KW'(r_col);
  end

  always_ff @(posedge i_int_osc or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StScan;
      r_row        <= '0;
      r_rows_n     <= RowsNReset;
      r_col        <= '0;
      r_dwell      <= '0;
      r_cnt        <= '0;
      r_rep        <= '0;
      r_key_code   <= '0;
      r_key_valid  <= 1'b0;
      r_key_repeat <= 1'b0;
      r_key_held   <= 1'b0;
    end else begin
      r_key_valid  <= 1'b0;
      r_key_repeat <= 1'b0;
      unique case (r_state)
        StScan: begin
          if (r_dwell == DwLast) begin
            r_dwell <= '0;
            if (w_one_hot) begin
              // Row stays frozen while the press is confirmed.
              r_col   <= w_low_idx;
              r_cnt   <= '0;
              r_state <= StDebounce;
            end else begin
              r_row    <= w_row_next;
              r_rows_n <= w_rows_n_next;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        StDebounce: begin
          if (r_sync2 != w_exp_cols) begin
            r_state  <= StScan;
            r_dwell  <= '0;
            r_row    <= w_row_next;
            r_rows_n <= w_rows_n_next;
          end else if (r_cnt == DbLast) begin
            r_key_code  <= w_code;
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= StEmit;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StEmit: begin
          r_state <= StHold;
          // Down-counter reaching 1 means the repeat strobe fires on the next cycle.
          if (REPEAT_EN != 0) begin
            r_rep <= RepFirst;
          end
        end
        StHold: begin
          if (w_col_high) begin
            r_state <= StRelease;
            r_cnt   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (r_rep == RepW'(1)) begin
              r_key_valid  <= 1'b1;
              r_key_repeat <= 1'b1;
              r_rep        <= RepReload;
            end else begin
              r_rep <= r_rep - 1'b1;
            end
          end
        end
        StRelease: begin
          // Repeat timer is paused here so a brief lift resumes it where it left off.
          if (!w_col_high) begin
            r_state <= StHold;
          end else if (r_cnt == DbLast) begin
            r_key_held <= 1'b0;
            r_state    <= StScan;
            r_dwell    <= '0;
            r_row      <= w_row_next;
            r_rows_n   <= w_rows_n_next;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StScan;
      endcase
    end
  end

  assign o_rows_n     = r_rows_n;
  assign o_key_code   = r_key_code;
  assign o_key_valid  = r_key_valid;
  assign o_key_repeat = r_key_repeat;
  assign o_key_held   = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a simulated key matrix drives the column pins from the row
// drive, a behavioural model predicts every output each cycle, and a few directed scenarios
// pin the model with hand-derived literal expectations.
module tb_keypad_scan_ctrl;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP_DLY  = 40;
  localparam int REP_RATE = 10;
  localparam int KW       = 4;

  localparam int MScan  = 0;
  localparam int MPress = 1;
  localparam int MEmit  = 2;
  localparam int MHold  = 3;
  localparam int MRel   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [COLS-1:0] cols_n;
  logic [ROWS-1:0] rows_n;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_repeat;
  logic            key_held;

  logic [ROWS*COLS-1:0] pressed = '0;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  int   ev_cyc[$];
  int   ev_code[$];
  logic ev_rep[$];

  // model state
  logic [COLS-1:0] m_hist[$];
  int   m_mode, m_row, m_dwell, m_lcol, m_cnt, m_since, m_code;
  logic m_valid, m_repeat, m_held;

  always #5 clk = ~clk;

  // Physical keypad: a column reads low when a closed key joins it to the driven row.
  always_comb begin
    cols_n = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (pressed[r*COLS+c] && !rows_n[r]) cols_n[c] = 1'b0;
      end
    end
  end

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_EN(1), .REPEAT_DELAY(REP_DLY), .REPEAT_RATE(REP_RATE)
  ) u_dut (
    .i_int_osc   (clk),
    .i_reset     (rst_n),
    .i_cols_n    (cols_n),
    .o_rows_n    (rows_n),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .o_key_repeat(key_repeat),
    .o_key_held  (key_held)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ROWS-1:0] m_rows();
    logic [ROWS-1:0] v;
    v = '1;
    v[m_row] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back('1);
    m_hist.push_back('1);
    m_mode = MScan; m_row = 0; m_dwell = 0; m_lcol = 0; m_cnt = 0; m_since = 0;
    m_code = 0; m_valid = 0; m_repeat = 0; m_held = 0;
  endtask

  task automatic model_next_row();
    m_row   = (m_row + 1) % ROWS;
    m_dwell = 0;
    m_mode  = MScan;
  endtask

  // Advance the model across one clock edge given the pin value seen at that edge.
  task automatic model_step(input logic [COLS-1:0] raw);
    logic [COLS-1:0] cs;
    int lows, idx;
    bit ok;
    cs = m_hist.pop_front();
    m_hist.push_back(raw);
    m_valid  = 0;
    m_repeat = 0;
    case (m_mode)
      MScan: begin
        if (m_dwell == SCAN_DIV - 1) begin
          lows = 0; idx = 0;
          for (int c = 0; c < COLS; c++) if (!cs[c]) begin lows++; idx = c; end
          if (lows == 1) begin
            m_lcol = idx; m_cnt = 0; m_mode = MPress;
          end else begin
            model_next_row();
          end
        end else begin
          m_dwell++;
        end
      end
      MPress: begin
        ok = 1;
        for (int c = 0; c < COLS; c++) if (cs[c] != (c != m_lcol)) ok = 0;
        if (!ok) model_next_row();
        else if (m_cnt == DEB - 1) begin
          m_code = m_row * COLS + m_lcol; m_valid = 1; m_held = 1; m_mode = MEmit;
        end else m_cnt++;
      end
      MEmit: begin
        m_mode = MHold; m_since = 1;
      end
      MHold: begin
        if (cs[m_lcol]) begin
          m_mode = MRel; m_cnt = 0;
        end else begin
          if (m_since + 1 >= REP_DLY && ((m_since + 1 - REP_DLY) % REP_RATE) == 0) begin
            m_valid = 1; m_repeat = 1;
          end
          m_since++;
        end
      end
      default: begin
        if (!cs[m_lcol]) m_mode = MHold;
        else if (m_cnt == DEB - 1) begin
          m_held = 0; model_next_row();
        end else m_cnt++;
      end
    endcase
  endtask

  // One clock: model sees the settled pins, then outputs are compared half a period later.
  task automatic cycle();
    #1;
    model_step(cols_n);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("rows_n", rows_n, m_rows());
    chk("key_code", key_code, m_code);
    chk("key_valid", key_valid, m_valid);
    chk("key_repeat", key_repeat, m_repeat);
    chk("key_held", key_held, m_held);
    if (key_valid === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(key_code);
      ev_rep.push_back(key_repeat);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_ev();
    ev_cyc.delete(); ev_code.delete(); ev_rep.delete();
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    pressed[r*COLS+c] = v;
  endtask

  task automatic run_until_valid(input int bound, output int n);
    n = 0;
    do begin cycle(); n++; end while (key_valid !== 1'b1 && n < bound);
    chk("valid_seen", key_valid, 1);
  endtask

  task automatic run_until_held_low(input int bound, output int n);
    n = 0;
    do begin cycle(); n++; end while (key_held !== 1'b0 && n < bound);
    chk("held_low_seen", key_held, 0);
  endtask

  // Called at a falling edge: reset is asserted, checked, then released a cycle later.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_rows_n", rows_n, 4'b1110);
    chk("reset_key_code", key_code, 0);
    chk("reset_key_valid", key_valid, 0);
    chk("reset_key_repeat", key_repeat, 0);
    chk("reset_key_held", key_held, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want test done");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, r, c, r2, c2, mode;
    logic [ROWS-1:0] seen;
    int exp_off[8];

    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-scan, then scan restarts on row 0.
    run(7);
    do_reset();
    run(3);
    chk("row0_after_reset", rows_n, 4'b1110);
    run(1);
    chk("row1_after_dwell", rows_n, 4'b1101);

    // Steady press of row2/col1.
    clear_ev();
    set_key(2, 1, 1'b1);
    run_until_valid(60, n);
    chk("press_latency_le_27", n <= 27, 1);
    run(20);
    chk("t2_one_event", ev_cyc.size(), 1);
    chk("t2_code", ev_code[0], 9);
    chk("t2_not_repeat", ev_rep[0], 0);
    set_key(2, 1, 1'b0);
    run_until_held_low(40, n);
    chk("t2_release_cycles", n, 2 + 1 + DEB);

    // Bouncing press of row1/col3.
    run(5);
    clear_ev();
    for (int i = 0; i < 5; i++) begin
      set_key(1, 3, 1'b1); run(3);
      set_key(1, 3, 1'b0); run(1);
    end
    chk("t3_no_event_in_bounce", ev_cyc.size(), 0);
    set_key(1, 3, 1'b1);
    run_until_valid(60, n);
    chk("t3_code", key_code, 7);
    set_key(1, 3, 1'b0);
    run_until_held_low(40, n);

    // Two keys on row 0: rejected until one lifts.
    clear_ev();
    set_key(0, 0, 1'b1);
    set_key(0, 2, 1'b1);
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      seen |= ~rows_n;
    end
    chk("t4_no_event", ev_cyc.size(), 0);
    chk("t4_rows_cycle", seen, 4'b1111);
    set_key(0, 2, 1'b0);
    run_until_valid(60, n);
    chk("t4_code", key_code, 0);
    set_key(0, 0, 1'b0);
    run_until_held_low(40, n);

    // Auto-repeat on row3/col3.
    clear_ev();
    set_key(3, 3, 1'b1);
    run_until_valid(60, n);
    e = cyc;
    run(100);
    exp_off = '{0, 40, 50, 60, 70, 80, 90, 100};
    chk("t5_event_count", ev_cyc.size(), 8);
    for (int i = 0; i < 8 && i < ev_cyc.size(); i++) begin
      chk("t5_offset", ev_cyc[i] - e, exp_off[i]);
      chk("t5_code", ev_code[i], 15);
      chk("t5_repeat_flag", ev_rep[i], i > 0);
    end
    set_key(3, 3, 1'b0);
    run_until_held_low(40, n);

    // Short lift during hold on key 5 does not re-emit.
    clear_ev();
    set_key(1, 1, 1'b1);
    run_until_valid(60, n);
    run(10);
    set_key(1, 1, 1'b0); run(4);
    set_key(1, 1, 1'b1); run(10);
    chk("t6_single_event", ev_cyc.size(), 1);
    chk("t6_still_held", key_held, 1);
    set_key(1, 1, 1'b0);
    run_until_held_low(40, n);
    chk("t6_resume_row2", rows_n, 4'b1011);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      mode = $urandom_range(0, 3);
      run($urandom_range(0, 20));
      if (mode == 1) begin
        for (int b = 0; b < $urandom_range(1, 4); b++) begin
          set_key(r, c, 1'b1); run($urandom_range(1, 5));
          set_key(r, c, 1'b0); run($urandom_range(1, 3));
        end
      end
      set_key(r, c, 1'b1);
      if (mode == 2) begin
        r2 = $urandom_range(0, ROWS - 1);
        c2 = $urandom_range(0, COLS - 1);
        set_key(r2, c2, 1'b1);
      end
      run($urandom_range(5, 90));
      if (mode == 3) begin
        do_reset();
        run($urandom_range(1, 10));
      end
      if ($urandom_range(0, 1) == 1) begin
        set_key(r, c, 1'b0); run($urandom_range(1, 5));
        set_key(r, c, 1'b1); run($urandom_range(1, 5));
      end
      pressed = '0;
      run(30);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Parametrised matrix-keypad controller that generalises the fixed 4x4 scan/debounce/hold sequencer. It adds an integrated row driver, internal column synchroniser, debounce and release-debounce timers, multi-key rejection, and an optional auto-repeat mode. It sits between the keypad pins and the key-storage/7-segment logic, delivering a binary key code with a one-cycle valid strobe.

Parameters:
ROWS, 4, number of keypad rows driven (2..8)
COLS, 4, number of keypad columns sensed (2..8)
SCAN_DIV, 16, int_osc cycles each row is driven before sampling (>=4)
DEBOUNCE_CYCLES, 50000, cycles a press or release must be stable to be accepted (>=2)
REPEAT_EN, 0, 1 enables auto-repeat while a key is held
REPEAT_DELAY, 24000000, cycles from first emit to first repeat
REPEAT_RATE, 4800000, cycles between subsequent repeats
KW, $clog2(ROWS*COLS), key_code width (derived, not overridden)

Ports:
int_osc  input  1  clock, single clock domain
reset  input  1  asynchronous, active-low reset
cols_n  input  COLS  raw column pins, active-low (pulled up), asynchronous
rows_n  output  ROWS  row drive, active-low, exactly one bit low at all times
key_code  output  KW  accepted key = row*COLS + col
key_valid  output  1  one-cycle pulse when key_code is updated (first press or repeat)
key_repeat  output  1  high with key_valid when the event is an auto-repeat
key_held  output  1  high from first emit until release is debounced

Behaviour:
- Reset (reset=0, async): state SCAN, row index 0, rows_n = all ones except bit0 low, key_code=0, key_valid=0, key_repeat=0, key_held=0, all counters and synchroniser flops cleared to "released" (all ones).
- cols_n passes a 2-flop synchroniser; all decisions use the synchronised value (cols_s). Deassertion of reset mid-operation always restarts in SCAN; no partial key is emitted.
- SCAN: dwell counter counts 0..SCAN_DIV-1 on the current row; on the last dwell cycle cols_s is sampled. Exactly one bit low -> latch row/col, go DEBOUNCE, row frozen. Zero bits low -> advance row (ROWS-1 wraps to 0), dwell restarts. Two or more bits low -> treated as no key, row advances.
- DEBOUNCE: counter runs DEBOUNCE_CYCLES. If latched col goes high, or any other col goes low, before expiry -> return to SCAN, advance row. On expiry with cols_s still one-hot on latched col -> EMIT.
- EMIT (1 cycle): key_code <= latched row*COLS+col, key_valid=1, key_repeat=0, key_held<=1; next HOLD. key_code holds its value until the next emit.
- HOLD: key_valid=0. Latched col high -> RELEASE. Extra columns pressed are ignored (first key locked). If REPEAT_EN: repeat timer counts; at REPEAT_DELAY cycles after EMIT, then every REPEAT_RATE cycles, a one-cycle key_valid with key_repeat=1 and unchanged key_code. With REPEAT_EN=0 no repeat logic is active.
- RELEASE: counter requires latched col high for DEBOUNCE_CYCLES consecutive cycles. Latched col low again -> back to HOLD with no new emit; the repeat timer resumes without reset. On expiry: key_held<=0, row advances, enter SCAN.
- key_valid never asserts in consecutive cycles; key_repeat is 0 whenever key_valid is 0.
- Latency (sync'd press stable): press->key_valid <= 2 + ROWS*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.
- Counter widths are sized by $clog2 of their maximum; no counter wraps silently.

Test Plan:
(ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_RATE=10 unless noted)
1. Assert reset mid-scan, then release -> rows_n=4'b1110, key_code=0, key_valid=0, key_held=0 within the reset cycle; scan resumes at row 0.
2. Hold row2/col1 closed steadily -> exactly one key_valid with key_code=9, key_repeat=0; key_held=1 until 8 cycles after release, then 0.
3. Press row1/col3 bouncing (low 3 cycles, high 1, repeat 5x) then stable -> no key_valid during bounce; one key_valid with key_code=7 after stabilising.
4. Press row0/col0 and row0/col2 together -> no key_valid, rows_n keeps cycling; release col2 -> key_valid with key_code=0.
5. REPEAT_EN=1, hold row3/col3 for 100 cycles after emit -> key_valid at emit, +40, +50, +60... with key_code=15 and key_repeat=1 on repeats only.
6. In HOLD on key 5, release for 4 cycles then re-press -> no new key_valid; key_held stays 1; full release for >=8 cycles -> key_held=0, scan resumes on row 2.
